// File: rtl/jtframe_joysched.sv
// Joystick scan scheduler: walks the players one per clock through a
// shared debounce and 4-way restriction stage on every sample tick.
module jtframe_joysched #(
  parameter int PLAYERS = 2,
  parameter int DEB     = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cen,
  input  logic                   enable,
  input  logic [4*PLAYERS-1:0]   joy_in,
  output logic [4*PLAYERS-1:0]   joy_out,
  output logic                   busy,
  output logic                   done,
  output logic                   miss
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  localparam logic [1:0] LAST = 2'(PLAYERS - 1);
  localparam logic [3:0] DEB4 = 4'(DEB);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic       miss_q, miss_d;

  logic [3:0] cand_q [PLAYERS];
  logic [3:0] cnt_q  [PLAYERS];
  logic [3:0] out_q  [PLAYERS];

  logic [3:0] s;
  logic [3:0] cand_sel;
  logic [3:0] cnt_sel;
  logic [3:0] cnt_nx;
  logic       same;
  logic       acc;
  logic       legal;
  logic       upd;
  logic       proc;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (cen) begin
          state_d = SCAN;
          idx_d   = 2'd0;
        end
      end
      SCAN: begin
        if (idx_q == LAST) state_d = DONE;
        else               idx_d   = idx_q + 2'd1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign miss   = miss_q;
  assign miss_d = cen && busy;
  assign proc   = (state_q == SCAN);

  // Shared stage: pick the slice and history of the player under scan
  always_comb begin
    s        = 4'd0;
    cand_sel = 4'd0;
    cnt_sel  = 4'd0;
    for (int p = 0; p < PLAYERS; p++) begin
      if (idx_q == 2'(p)) begin
        s        = joy_in[4*p +: 4];
        cand_sel = cand_q[p];
        cnt_sel  = cnt_q[p];
      end
    end
  end

  always_comb begin
    same = (s == cand_sel);
    if (!same)               cnt_nx = 4'd1;
    else if (cnt_sel >= DEB4) cnt_nx = DEB4;
    else                     cnt_nx = cnt_sel + 4'd1;
    acc   = (cnt_nx >= DEB4);
    legal = ((s & (s - 4'd1)) == 4'd0);
    upd   = acc && (!enable || legal);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      miss_q  <= miss_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < PLAYERS; p++) begin
        cand_q[p] <= 4'd0;
        cnt_q[p]  <= 4'd0;
        out_q[p]  <= 4'd0;
      end
    end else if (proc) begin
      for (int p = 0; p < PLAYERS; p++) begin
        if (idx_q == 2'(p)) begin
          cand_q[p] <= s;
          cnt_q[p]  <= cnt_nx;
          if (upd) out_q[p] <= s;
        end
      end
    end
  end

  always_comb begin
    joy_out = '0;
    for (int p = 0; p < PLAYERS; p++) begin
      joy_out[4*p +: 4] = out_q[p];
    end
  end

endmodule

// File: tb/tb_jtframe_joysched.sv
// Bench for jtframe_joysched: four configurations checked against a
// sample-history reference model plus directed timing scenarios.
module tb_jtframe_joysched;

  localparam int PL [4] = '{2, 2, 4, 1};
  localparam int DB [4] = '{2, 1, 1, 3};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        cen [4];
  logic        en  [4];
  logic        bz  [4];
  logic        dn  [4];
  logic        ms  [4];
  logic [7:0]  ji0, ji1, jo0, jo1;
  logic [15:0] ji2, jo2;
  logic [3:0]  ji3, jo3;

  int n_chk  = 0;
  int n_fail = 0;

  jtframe_joysched #(.PLAYERS(2), .DEB(2)) u0 (
    .clk(clk), .rst_n(rst_n), .cen(cen[0]), .enable(en[0]),
    .joy_in(ji0), .joy_out(jo0), .busy(bz[0]), .done(dn[0]), .miss(ms[0]));
  jtframe_joysched #(.PLAYERS(2), .DEB(1)) u1 (
    .clk(clk), .rst_n(rst_n), .cen(cen[1]), .enable(en[1]),
    .joy_in(ji1), .joy_out(jo1), .busy(bz[1]), .done(dn[1]), .miss(ms[1]));
  jtframe_joysched #(.PLAYERS(4), .DEB(1)) u2 (
    .clk(clk), .rst_n(rst_n), .cen(cen[2]), .enable(en[2]),
    .joy_in(ji2), .joy_out(jo2), .busy(bz[2]), .done(dn[2]), .miss(ms[2]));
  jtframe_joysched #(.PLAYERS(1), .DEB(3)) u3 (
    .clk(clk), .rst_n(rst_n), .cen(cen[3]), .enable(en[3]),
    .joy_in(ji3), .joy_out(jo3), .busy(bz[3]), .done(dn[3]), .miss(ms[3]));

  // Reference model: scan start times plus per-player sample history
  int         cyc;
  int         start [4];
  bit         mq    [4];
  logic [3:0] mo    [4][4];
  logic [3:0] h     [4][4][16];
  int         nh    [4][4];

  function automatic logic [15:0] jin_of(int i);
    case (i)
      0: return {8'h0, ji0};
      1: return {8'h0, ji1};
      2: return ji2;
      default: return {12'h0, ji3};
    endcase
  endfunction

  function automatic logic [15:0] jout_of(int i);
    case (i)
      0: return {8'h0, jo0};
      1: return {8'h0, jo1};
      2: return jo2;
      default: return {12'h0, jo3};
    endcase
  endfunction

  function automatic logic [15:0] exp_out(int i);
    logic [15:0] e;
    e = '0;
    for (int p = 0; p < PL[i]; p++) e[4*p +: 4] = mo[i][p];
    return e;
  endfunction

  function automatic bit exp_busy(int i);
    return (cyc > start[i]) && (cyc <= start[i] + PL[i] + 1);
  endfunction

  function automatic bit exp_done(int i);
    return cyc == start[i] + PL[i] + 1;
  endfunction

  task automatic setj(int i, logic [15:0] v);
    case (i)
      0: ji0 = v[7:0];
      1: ji1 = v[7:0];
      2: ji2 = v;
      default: ji3 = v[3:0];
    endcase
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      start[i] = -1000;
      mq[i]    = 1'b0;
      for (int p = 0; p < 4; p++) begin
        mo[i][p] = 4'd0;
        nh[i][p] = 0;
      end
    end
  endtask

  // Advance one clock; the model consumes the inputs of the ending cycle
  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int i = 0; i < 4; i++) begin
        bit          b;
        bit          ok;
        int          k;
        logic [3:0]  s;
        logic [15:0] v;
        b = exp_busy(i);
        k = cyc - start[i] - 1;
        if (k >= 0 && k < PL[i]) begin
          v = jin_of(i);
          s = v[4*k +: 4];
          for (int j = 15; j > 0; j--) h[i][k][j] = h[i][k][j-1];
          h[i][k][0] = s;
          if (nh[i][k] < 16) nh[i][k]++;
          ok = nh[i][k] >= DB[i];
          for (int j = 0; j < DB[i]; j++) if (h[i][k][j] !== s) ok = 1'b0;
          if (ok && (!en[i] || $countones(s) <= 1)) mo[i][k] = s;
        end
        mq[i] = cen[i] && b;
        if (cen[i] && !b) start[i] = cyc;
      end
      cyc++;
    end
    #1;
  endtask

  task automatic run_scan(int i);
    cen[i] = 1'b1;
    step();
    cen[i] = 1'b0;
    repeat (PL[i] + 1) step();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if ({bz[i], dn[i], ms[i]} !== 3'b000 || jout_of(i) !== 16'h0) begin
        n_fail++;
        $display("FAIL reset_state inst%0d: got b%b d%b m%b out %h want 0",
                 i, bz[i], dn[i], ms[i], jout_of(i));
      end
    end
    rst_n = 1'b1;
    en[2] = 1'b0;
    setj(2, 16'hFFFF);
    run_scan(2);
    n_chk++;
    if (jo2 !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL reset_preload: got %h want ffff", jo2);
    end
    cen[2] = 1'b1;
    step();
    cen[2] = 1'b0;
    step();
    rst_n = 1'b0;
    model_reset();
    #1;
    n_chk++;
    if (jo2 !== 16'h0 || bz[2] !== 1'b0 || dn[2] !== 1'b0 || ms[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midscan: got out %h b%b d%b m%b want 0",
               jo2, bz[2], dn[2], ms[2]);
    end
    step();
    step();
    rst_n = 1'b1;
    for (int r = 0; r < 10; r++) begin
      @(negedge clk);
      n_chk++;
      if (dn[2] !== 1'b0 || bz[2] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_no_done r%0d: got d%b b%b want 0 0", r, dn[2], bz[2]);
      end
      step();
    end
  endtask

  task automatic test_timing();
    logic [15:0] v;
    logic [15:0] e;
    v = 16'h8421;
    en[2] = 1'b0;
    setj(2, v);
    for (int r = 0; r < 8; r++) begin
      cen[2] = (r == 0);
      @(negedge clk);
      e = '0;
      for (int p = 0; p < 4; p++) if (r >= p + 2) e[4*p +: 4] = v[4*p +: 4];
      n_chk++;
      if (bz[2] !== (r >= 1 && r <= 5)) begin
        n_fail++;
        $display("FAIL timing_busy r%0d: got %b", r, bz[2]);
      end
      n_chk++;
      if (dn[2] !== (r == 5)) begin
        n_fail++;
        $display("FAIL timing_done r%0d: got %b", r, dn[2]);
      end
      n_chk++;
      if (jo2 !== e) begin
        n_fail++;
        $display("FAIL timing_out r%0d: got %h want %h", r, jo2, e);
      end
      step();
    end
  endtask

  task automatic test_debounce();
    en[0] = 1'b0;
    setj(0, 16'h0001);
    run_scan(0);
    n_chk++;
    if (jo0[3:0] !== 4'h0) begin
      n_fail++;
      $display("FAIL deb_first: got %h want 0", jo0[3:0]);
    end
    for (int r = 0; r < 5; r++) begin
      cen[0] = (r == 0);
      @(negedge clk);
      if (r <= 2) begin
        n_chk++;
        if (jo0[3:0] !== ((r == 2) ? 4'h1 : 4'h0)) begin
          n_fail++;
          $display("FAIL deb_second r%0d: got %h want %h", r, jo0[3:0],
                   (r == 2) ? 4'h1 : 4'h0);
        end
      end
      step();
    end
    for (int t = 0; t < 6; t++) begin
      setj(0, {8'h0, (t % 2 == 1) ? 4'h2 : 4'h1, 4'h1});
      run_scan(0);
      n_chk++;
      if (jo0 !== 8'h01) begin
        n_fail++;
        $display("FAIL deb_alternate t%0d: got %h want 01", t, jo0);
      end
    end
  endtask

  task automatic test_fourway();
    logic [3:0] sq [5];
    logic [3:0] e4 [5];
    sq = '{4'h8, 4'hA, 4'h2, 4'hC, 4'h0};
    e4 = '{4'h8, 4'h8, 4'h2, 4'h2, 4'h0};
    for (int pass = 0; pass < 2; pass++) begin
      en[1] = (pass == 0);
      for (int t = 0; t < 5; t++) begin
        setj(1, {8'h0, sq[t], 4'h0});
        run_scan(1);
        n_chk++;
        if (jo1[7:4] !== ((pass == 0) ? e4[t] : sq[t])) begin
          n_fail++;
          $display("FAIL fourway en%0d t%0d: got %h want %h", en[1], t,
                   jo1[7:4], (pass == 0) ? e4[t] : sq[t]);
        end
      end
    end
  endtask

  task automatic test_midscan_enable();
    en[1] = 1'b0;
    setj(1, 16'h0008);
    run_scan(1);
    setj(1, 16'h0055);
    en[1]  = 1'b1;
    cen[1] = 1'b1;
    step();
    cen[1] = 1'b0;
    step();
    en[1] = 1'b0;
    repeat (2) step();
    n_chk++;
    if (jo1[3:0] !== 4'h8) begin
      n_fail++;
      $display("FAIL midscan_p0: got %h want 8", jo1[3:0]);
    end
    n_chk++;
    if (jo1[7:4] !== 4'h5) begin
      n_fail++;
      $display("FAIL midscan_p1: got %h want 5", jo1[7:4]);
    end
  endtask

  task automatic test_overrun();
    for (int r = 0; r < 9; r++) begin
      cen[0] = (r == 0 || r == 2 || r == 4);
      @(negedge clk);
      n_chk++;
      if (dn[0] !== (r == 3 || r == 7)) begin
        n_fail++;
        $display("FAIL overrun_done r%0d: got %b", r, dn[0]);
      end
      n_chk++;
      if (ms[0] !== (r == 3)) begin
        n_fail++;
        $display("FAIL overrun_miss r%0d: got %b", r, ms[0]);
      end
      n_chk++;
      if (bz[0] !== ((r >= 1 && r <= 3) || (r >= 5 && r <= 7))) begin
        n_fail++;
        $display("FAIL overrun_busy r%0d: got %b", r, bz[0]);
      end
      step();
    end
  endtask

  function automatic logic [3:0] pick();
    case ($urandom_range(0, 5))
      0: return 4'h0;
      1: return 4'h1;
      2: return 4'h2;
      3: return 4'h4;
      4: return 4'h8;
      default: return 4'($urandom_range(0, 15));
    endcase
  endfunction

  task automatic test_random();
    logic [15:0] v;
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 4; i++) begin
        cen[i] = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 7) == 0) en[i] = ~en[i];
        v = jin_of(i);
        for (int p = 0; p < PL[i]; p++)
          if ($urandom_range(0, 3) == 0) v[4*p +: 4] = pick();
        setj(i, v);
      end
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        n_chk++;
        if (bz[i] !== exp_busy(i) || dn[i] !== exp_done(i) || ms[i] !== mq[i]) begin
          n_fail++;
          $display("FAIL rand_ctl inst%0d cyc%0d: got b%b d%b m%b want b%b d%b m%b",
                   i, cyc, bz[i], dn[i], ms[i], exp_busy(i), exp_done(i), mq[i]);
        end
        n_chk++;
        if (jout_of(i) !== exp_out(i)) begin
          n_fail++;
          $display("FAIL rand_out inst%0d cyc%0d: got %h want %h",
                   i, cyc, jout_of(i), exp_out(i));
        end
      end
      step();
    end
    for (int i = 0; i < 4; i++) cen[i] = 1'b0;
    repeat (8) step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc   = 0;
    rst_n = 1'b0;
    ji0 = '0;
    ji1 = '0;
    ji2 = '0;
    ji3 = '0;
    for (int i = 0; i < 4; i++) begin
      cen[i] = 1'b0;
      en[i]  = 1'b0;
    end
    model_reset();
    repeat (3) step();
    test_reset();
    test_timing();
    test_debounce();
    test_fourway();
    test_midscan_enable();
    test_overrun();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
